// File: rtl/regfile_writeback_arbiter_if.sv
// Writeback bundle: two source handshakes in, two register-file write ports
// and the pending-write scoreboard out.
interface regfile_writeback_arbiter_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3
);
   localparam int NREG = 2 ** ADDR_WIDTH;

   logic                  src0_valid;
   logic                  src0_ready;
   logic [ADDR_WIDTH-1:0] src0_addr;
   logic [DATA_WIDTH-1:0] src0_data;
   logic                  src1_valid;
   logic                  src1_ready;
   logic [ADDR_WIDTH-1:0] src1_addr;
   logic [DATA_WIDTH-1:0] src1_data;

   logic                  we1;
   logic [ADDR_WIDTH-1:0] write_addr1;
   logic [DATA_WIDTH-1:0] write_data1;
   logic                  we2;
   logic [ADDR_WIDTH-1:0] write_addr2;
   logic [DATA_WIDTH-1:0] write_data2;
   logic [NREG-1:0]       pending_mask;
   logic                  busy;

   // Handshake: a beat transfers on a rising edge where srcN_valid and
   // srcN_ready are both 1; ready is registered and never depends on valid.
   modport master (
      output src0_valid, src0_addr, src0_data,
      output src1_valid, src1_addr, src1_data,
      input  src0_ready, src1_ready,
      input  we1, write_addr1, write_data1,
      input  we2, write_addr2, write_data2,
      input  pending_mask, busy
   );

   modport slave (
      input  src0_valid, src0_addr, src0_data,
      input  src1_valid, src1_addr, src1_data,
      output src0_ready, src1_ready,
      output we1, write_addr1, write_data1,
      output we2, write_addr2, write_data2,
      output pending_mask, busy
   );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Two-source writeback front end: per-source FIFOs, collision-aware issue onto
// the register file's two write ports, and a per-register pending-write count.
module regfile_writeback_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3,
   parameter int FIFO_DEPTH = 4
) (
   input logic                     clk,
   input logic                     rst,
   regfile_writeback_arbiter_if.slave wb
);
   localparam int NREG = 2 ** ADDR_WIDTH;
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CW   = $clog2(2 * FIFO_DEPTH + 3);
   localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];

   logic [DATA_WIDTH-1:0] data_mem [2][FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] addr_mem [2][FIFO_DEPTH];
   logic [PW:0]           wr_ptr [2];
   logic [PW:0]           rd_ptr [2];
   logic [PW:0]           count_next [2];
   logic [1:0]            ready_q;
   logic [1:0]            in_valid;
   logic [1:0]            push;
   logic [1:0]            pop;
   logic [1:0]            head_valid;
   logic [ADDR_WIDTH-1:0] in_addr [2];
   logic [DATA_WIDTH-1:0] in_data [2];
   logic [ADDR_WIDTH-1:0] head_addr [2];
   logic [DATA_WIDTH-1:0] head_data [2];

   logic [1:0]            we_q;
   logic [ADDR_WIDTH-1:0] waddr_q [2];
   logic [DATA_WIDTH-1:0] wdata_q [2];

   logic [CW-1:0]         cnt [NREG];
   logic [CW-1:0]         cnt_next [NREG];

   always_comb begin
      in_valid   = {wb.src1_valid, wb.src0_valid};
      in_addr[0] = wb.src0_addr;
      in_addr[1] = wb.src1_addr;
      in_data[0] = wb.src0_data;
      in_data[1] = wb.src1_data;
      push       = in_valid & ready_q;
      for (int k = 0; k < 2; k++) begin
         head_valid[k] = (wr_ptr[k] != rd_ptr[k]);
         head_addr[k]  = addr_mem[k][rd_ptr[k][PW-1:0]];
         head_data[k]  = data_mem[k][rd_ptr[k][PW-1:0]];
      end
      // Source 0 is older: on a same-address collision only head0 issues,
      // so port 2 writes that register strictly later.
      pop[0] = head_valid[0];
      pop[1] = head_valid[1] & ~(head_valid[0] && (head_addr[0] == head_addr[1]));
      for (int k = 0; k < 2; k++) begin
         count_next[k] = (wr_ptr[k] - rd_ptr[k]) + {{PW{1'b0}}, push[k]}
                         - {{PW{1'b0}}, pop[k]};
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (push[k]) begin
            data_mem[k][wr_ptr[k][PW-1:0]] <= in_data[k];
            addr_mem[k][wr_ptr[k][PW-1:0]] <= in_addr[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            wr_ptr[k]  <= '0;
            rd_ptr[k]  <= '0;
            waddr_q[k] <= '0;
            wdata_q[k] <= '0;
         end
         ready_q <= '0;
         we_q    <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
            if (pop[k]) begin
               rd_ptr[k]  <= rd_ptr[k] + 1'b1;
               waddr_q[k] <= head_addr[k];
               wdata_q[k] <= head_data[k];
            end
            ready_q[k] <= (count_next[k] != FULL_CNT);
         end
         we_q <= pop;
      end
   end

   // Accepted beats count up; each write counts down at its commit edge.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         cnt_next[i] = cnt[i]
            + CW'(push[0] && (in_addr[0] == ADDR_WIDTH'(i)))
            + CW'(push[1] && (in_addr[1] == ADDR_WIDTH'(i)))
            - CW'(we_q[0] && (waddr_q[0] == ADDR_WIDTH'(i)))
            - CW'(we_q[1] && (waddr_q[1] == ADDR_WIDTH'(i)));
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         if (rst) cnt[i] <= '0;
         else     cnt[i] <= cnt_next[i];
      end
   end

   always_comb begin
      for (int i = 0; i < NREG; i++) wb.pending_mask[i] = (cnt[i] != '0);
   end

   assign wb.src0_ready  = ready_q[0];
   assign wb.src1_ready  = ready_q[1];
   assign wb.we1         = we_q[0];
   assign wb.write_addr1 = waddr_q[0];
   assign wb.write_data1 = wdata_q[0];
   assign wb.we2         = we_q[1];
   assign wb.write_addr2 = waddr_q[1];
   assign wb.write_data2 = wdata_q[1];
   assign wb.busy        = (|head_valid) | (|we_q);
endmodule

// File: doc/regfile_writeback_arbiter.md
# regfile_writeback_arbiter

Writer-side front end for the dual-write-port 8x16 register file. It accepts writeback results from two independent pipeline sources over valid/ready handshakes, buffers each source in a small FIFO, and schedules them onto the register file's two write ports. Same-address collisions are serialized in source order instead of relying on port-2 priority. It also exports a per-register pending-write scoreboard so issue logic can stall reads of registers with writes still in flight.

## Interface
- DATA_WIDTH, 16, register data width
- ADDR_WIDTH, 3, register address width; number of registers NREG = 2**ADDR_WIDTH
- FIFO_DEPTH, 4, entries per source FIFO (power of two, >= 2)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- src0_valid / src0_ready  in / out  1  source 0 handshake; source 0 is always the older source
- src0_addr  in  ADDR_WIDTH  destination register
- src0_data  in  DATA_WIDTH  result value
- src1_valid / src1_ready / src1_addr / src1_data  same as source 0, for source 1
- we1, write_addr1, write_data1  out  1 / ADDR_WIDTH / DATA_WIDTH  register-file write port 1; carries only source 0 entries
- we2, write_addr2, write_data2  out  1 / ADDR_WIDTH / DATA_WIDTH  register-file write port 2; carries only source 1 entries
- pending_mask  out  NREG  bit i = 1 while any accepted, uncommitted write targets register i
- busy  out  1  1 while any FIFO entry or asserted we exists

## Operation
- Beat accepted when srcN_valid & srcN_ready at a rising edge. srcN_ready = !rst_q & FIFO N not full. The ready signal is registered and does not depend on srcN_valid.
- Scheduler evaluates both FIFO heads every cycle:
  - Only head0 valid: issue head0 on port 1.
  - Only head1 valid: issue head1 on port 2.
  - Both valid, addresses differ: issue both.
  - Both valid, same address: issue head0 only. head1 issues next cycle at the earliest. Register-file end value is head1's data.
- Issue pops the FIFO head and loads the port register (we, addr, data). A port not issuing has we = 0. Addr and data hold their last values.
- Scoreboard: one counter per register, width clog2(2*FIFO_DEPTH+3).
  - +1 per accepted beat to that register. Two sources accepted to the same register in one cycle: +2.
  - −1 per asserted we to that register in the cycle its write commits.
  - Increment and decrement in the same cycle net out.
  - pending_mask[i] = (cnt[i] != 0).
- Reset (any cycle, including mid-stream):
  - Both FIFOs empty. All counters 0.
  - we1 = we2 = 0; write_addr* = 0; write_data* = 0; pending_mask = 0; busy = 0; src*_ready = 0.
  - Queued writes are discarded, never written.
  - src*_ready returns to 1 on the first cycle after rst deasserts.

## Timing
- Beat accepted at edge E. If its FIFO was empty and there is no collision, weN is high in the cycle following edge E+1, and the register file commits at edge E+2. Latency is 2 cycles.
- Sustained throughput: 1 beat/cycle per source with no collisions. Each same-address collision costs source 1 one cycle.
- FIFO full: ready drops in the cycle after the beat that filled it. Pop and push in the same cycle on a full FIFO are not allowed, because ready is already 0.
- pending_mask bit rises the cycle after acceptance. It falls the cycle after the commit edge of the last outstanding write to that register.
- FIFO pointers wrap modulo FIFO_DEPTH. The full/empty distinction uses an extra pointer bit.

## Test plan
- Reset: hold rst 2 cycles with src*_valid = 1 → we1 = we2 = 0, pending_mask = 0, ready = 0 throughout; ready = 1 one cycle after release.
- Single write: src0 addr 1 data AAAA → we1 with write_addr1 = 1 and data AAAA exactly 2 edges after acceptance; pending_mask[1] rises then clears; no we2.
- Parallel: src0 (2, BBBB) and src1 (5, CCCC) in the same cycle → we1 and we2 both high in the same cycle; the file holds R2 = BBBB, R5 = CCCC.
- Collision: src0 (3, 1234) and src1 (3, 5678) in the same cycle → we1 (3, 1234) one cycle, then we2 (3, 5678) the next cycle; R3 = 5678; pending_mask[3] is held across both and its counter peaks at 2.
- Backpressure: src1 valid for 8 cycles with the scheduler stalled by continuous collisions → ready low after 4 unissued entries; no beat lost or duplicated; order preserved (data 0..7 committed in order).
- Reset mid-stream: assert rst with 3 entries queued → no further we pulses, pending_mask = 0 and busy = 0 on the next cycle.
